// File: rtl/psum_collector_if.sv
// rtl/psum_collector_if.sv - tile control, skewed psum input and row-drain handshake bundle for psum_collector
interface psum_collector_if #(
    parameter int WIDTH     = 8,
    parameter int COLS      = 4,
    parameter int ROWS      = 4,
    parameter int ACC_WIDTH = 24
);
    localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                      Start;
    logic                      Accumulate;
    logic                      Last;
    logic [COLS*2*WIDTH-1:0]   PsumIn;
    logic                      Busy;
    logic                      Out_Valid;
    logic                      Out_Ready;
    logic [COLS*ACC_WIDTH-1:0] Out_Data;
    logic [PW-1:0]             Out_Row;
    logic                      Done;

    modport master (
        output Start, Accumulate, Last, PsumIn, Out_Ready,
        input  Busy, Out_Valid, Out_Data, Out_Row, Done
    );

    modport slave (
        input  Start, Accumulate, Last, PsumIn, Out_Ready,
        output Busy, Out_Valid, Out_Data, Out_Row, Done
    );
endinterface

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - de-skews systolic psums into rows, accumulates across K-tiles, drains rows; PSUM_SATURATE_EN selects saturating accumulate
module psum_collector #(
    parameter int WIDTH     = 8,
    parameter int COLS      = 4,
    parameter int ROWS      = 4,
    parameter int ACC_WIDTH = 24
) (
    input  logic           CLK,
    input  logic           RST,
    psum_collector_if.slave bus
);
    localparam int PW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int KW  = $clog2(ROWS + COLS);
    localparam int PSW = 2 * WIDTH;
    localparam logic [KW-1:0] K_FIRST = KW'(COLS - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(ROWS + COLS - 2);
    localparam logic [PW-1:0] P_LAST  = PW'(ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [KW-1:0]             k_q;
    logic                      acc_q, last_q;
    logic                      out_valid_q, done_q;
    logic [COLS*ACC_WIDTH-1:0] out_data_q;
    logic [PW-1:0]             out_row_q;
    logic [ACC_WIDTH-1:0]      bank [ROWS][COLS];

    logic                      collecting, collect_end, wr_en, accept, final_accept, load_first;
    logic                      acc_eff, last_eff;
    logic [KW-1:0]             cur_k;
    logic [PW-1:0]             wr_row, rd_row;
    logic [PSW-1:0]            aligned [COLS];
    logic [ACC_WIDTH-1:0]      new_row [COLS];
    logic [COLS*ACC_WIDTH-1:0] rd_data;

    // The Start cycle itself is k=0, so the window is evaluated from IDLE too.
    assign collecting   = (state_q == S_COLLECT) || ((state_q == S_IDLE) && bus.Start);
    assign cur_k        = (state_q == S_COLLECT) ? k_q : '0;
    assign acc_eff      = (state_q == S_COLLECT) ? acc_q : bus.Accumulate;
    assign last_eff     = (state_q == S_COLLECT) ? last_q : bus.Last;
    assign collect_end  = collecting && (cur_k == K_LAST);
    assign wr_en        = collecting && (cur_k >= K_FIRST);
    assign wr_row       = PW'(cur_k - K_FIRST);
    assign accept       = (state_q == S_DRAIN) && out_valid_q && bus.Out_Ready;
    assign final_accept = accept && (out_row_q == P_LAST);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_direct
            assign aligned[c] = bus.PsumIn[c*PSW +: PSW];
        end else begin : g_delay
            logic [PSW-1:0] sr [D];
            always_ff @(posedge CLK) begin
                if (!RST) begin
                    for (int i = 0; i < D; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= bus.PsumIn[c*PSW +: PSW];
                    for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
                end
            end
            assign aligned[c] = sr[D-1];
        end
    end

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
`ifdef PSUM_SATURATE_EN
            logic [ACC_WIDTH:0] sum;
            sum = (ACC_WIDTH+1)'(bank[wr_row][c]) + (ACC_WIDTH+1)'(aligned[c]);
            if (!acc_eff)
                new_row[c] = ACC_WIDTH'(aligned[c]);
            else if (sum[ACC_WIDTH])
                new_row[c] = '1;
            else
                new_row[c] = sum[ACC_WIDTH-1:0];
`else
            if (!acc_eff)
                new_row[c] = ACC_WIDTH'(aligned[c]);
            else
                new_row[c] = bank[wr_row][c] + ACC_WIDTH'(aligned[c]);
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        load_first = 1'b0;
        unique case (state_q)
            S_IDLE:    if (bus.Start) state_d = S_COLLECT;
            S_COLLECT: state_d = S_COLLECT;
            S_DRAIN:   if (final_accept) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (collect_end) begin
            state_d    = last_eff ? S_DRAIN : S_IDLE;
            load_first = last_eff;
        end
    end

    // Row 0 may be written on the same edge it is first presented (ROWS=1), so forward it.
    always_comb begin
        rd_row = load_first ? '0 : out_row_q + 1'b1;
        for (int c = 0; c < COLS; c++) begin
            rd_data[c*ACC_WIDTH +: ACC_WIDTH] = (load_first && wr_en && (wr_row == '0))
                                                ? new_row[c] : bank[rd_row][c];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            k_q         <= '0;
            acc_q       <= 1'b0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            done_q      <= 1'b0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    bank[r][c] <= '0;
        end else begin
            done_q <= final_accept;
            if ((state_q == S_IDLE) && bus.Start) begin
                k_q    <= KW'(1);
                acc_q  <= bus.Accumulate;
                last_q <= bus.Last;
            end else if (state_q == S_COLLECT) begin
                k_q <= k_q + 1'b1;
            end
            if (collect_end) k_q <= '0;

            if (wr_en)
                for (int c = 0; c < COLS; c++)
                    bank[wr_row][c] <= new_row[c];

            if (load_first) begin
                out_valid_q <= 1'b1;
                out_data_q  <= rd_data;
                out_row_q   <= '0;
            end else if (accept) begin
                if (final_accept) begin
                    out_valid_q <= 1'b0;
                end else begin
                    out_data_q <= rd_data;
                    out_row_q  <= rd_row;
                end
            end
        end
    end

    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.Out_Valid = out_valid_q;
    assign bus.Out_Data  = out_data_q;
    assign bus.Out_Row   = out_row_q;
    assign bus.Done      = done_q;
endmodule

// File: tb/tb_psum_collector.sv
// tb/tb_psum_collector.sv - scoreboard bench for psum_collector: tiles, accumulate, backpressure, ignored Start, reset, overflow
module tb_psum_collector;
    localparam int WIDTH = 8, COLS = 4, ROWS = 4, ACC_WIDTH = 24;
    localparam int NK = ROWS + COLS - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psum_collector_if #(.WIDTH(WIDTH), .COLS(COLS), .ROWS(ROWS), .ACC_WIDTH(ACC_WIDTH)) bus ();

    psum_collector #(.WIDTH(WIDTH), .COLS(COLS), .ROWS(ROWS), .ACC_WIDTH(ACC_WIDTH)) dut (
        .CLK(clk),
        .RST(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]                row;
        logic [COLS*ACC_WIDTH-1:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ps  [ROWS][COLS];
    logic [23:0] mdl [ROWS][COLS];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [23:0] upd(input logic [23:0] b, input logic [15:0] p, input bit acc);
        logic [24:0] s;
        if (!acc) return {8'h00, p};
        s = {1'b0, b} + {9'h000, p};
`ifdef PSUM_SATURATE_EN
        if (s[24]) return 24'hFFFFFF;
`endif
        return s[23:0];
    endfunction

    task automatic set_ps_const(input logic [15:0] v);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                ps[r][c] = v;
    endtask

    task automatic clear_model();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mdl[r][c] = '0;
    endtask

    // abort_k >= 0 pulls reset during that cycle and discards the tile
    task automatic send_tile(input bit acc, input bit last, input int glitch_k, input int abort_k);
        for (int k = 0; k < NK; k++) begin
            @(posedge clk); #1;
            bus.Start      = (k == 0) || (k == glitch_k);
            bus.Accumulate = (k == 0) ? acc : ~acc;
            bus.Last       = (k == 0) ? last : ~last;
            for (int c = 0; c < COLS; c++) begin
                int r;
                r = k - c;
                bus.PsumIn[c*16 +: 16] = (r >= 0 && r < ROWS) ? ps[r][c] : 16'($urandom);
            end
            if (k == abort_k) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n     = 1'b1;
                bus.Start = 1'b0;
                clear_model();
                @(negedge clk);
                total++;
                if (bus.Busy !== 1'b0 || bus.Out_Valid !== 1'b0) begin
                    bad++;
                    $display("FAIL abort_reset busy=%b valid=%b want 0 0", bus.Busy, bus.Out_Valid);
                end
                return;
            end
            @(negedge clk);
            total++;
            if (bus.Busy !== (k > 0)) begin
                bad++;
                $display("FAIL busy_collect k=%0d got=%b want=%b", k, bus.Busy, (k > 0));
            end
        end
        @(posedge clk); #1;
        bus.Start  = 1'b0;
        bus.PsumIn = {$urandom, $urandom};
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mdl[r][c] = upd(mdl[r][c], ps[r][c], acc);
        if (last) begin
            for (int r = 0; r < ROWS; r++) begin
                exp_t e;
                e.row = 2'(r);
                for (int c = 0; c < COLS; c++) e.data[c*ACC_WIDTH +: ACC_WIDTH] = mdl[r][c];
                sb.push_back(e);
            end
        end
    endtask

    task automatic drain(input int stall_row, input int nstall, input bit glitch);
        int guard = 0;
        int stalls = nstall;
        bit holding = 0;
        logic [COLS*ACC_WIDTH-1:0] hd;
        logic [1:0] hr;
        exp_t e;
        while (sb.size() > 0 && guard < 60) begin
            @(negedge clk);
            guard++;
            if (glitch && guard == 2) begin
                bus.Start      = 1'b1;
                bus.Accumulate = 1'($urandom);
                bus.Last       = 1'($urandom);
            end else begin
                bus.Start = 1'b0;
            end
            total++;
            if (bus.Done !== 1'b0) begin
                bad++;
                $display("FAIL early_done cycle=%0d got=%b want=0", guard, bus.Done);
            end
            if (guard == 1) begin
                total++;
                if (bus.Out_Valid !== 1'b1) begin
                    bad++;
                    $display("FAIL first_valid got=%b want=1", bus.Out_Valid);
                end
            end
            if (holding) begin
                total++;
                if (bus.Out_Valid !== 1'b1 || bus.Out_Data !== hd || bus.Out_Row !== hr) begin
                    bad++;
                    $display("FAIL hold valid=%b row=%0d data=%h want row=%0d data=%h",
                             bus.Out_Valid, bus.Out_Row, bus.Out_Data, hr, hd);
                end
            end
            if (bus.Out_Valid === 1'b1) begin
                if (int'(bus.Out_Row) == stall_row && stalls > 0) begin
                    stalls--;
                    holding       = 1;
                    hd            = bus.Out_Data;
                    hr            = bus.Out_Row;
                    bus.Out_Ready = 1'b0;
                end else begin
                    holding       = 0;
                    bus.Out_Ready = 1'b1;
                    e = sb.pop_front();
                    total++;
                    if (bus.Out_Row !== e.row || bus.Out_Data !== e.data) begin
                        bad++;
                        $display("FAIL row_data row=%0d data=%h want row=%0d data=%h",
                                 bus.Out_Row, bus.Out_Data, e.row, e.data);
                    end
                end
            end else begin
                holding       = 0;
                bus.Out_Ready = 1'($urandom);
            end
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout rows_left=%0d want 0", sb.size());
            sb.delete();
            bus.Out_Ready = 1'b0;
            return;
        end
        @(negedge clk);
        bus.Out_Ready = 1'b0;
        total++;
        if (bus.Out_Valid !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b1) begin
            bad++;
            $display("FAIL done_pulse valid=%b busy=%b done=%b want 0 0 1", bus.Out_Valid, bus.Busy, bus.Done);
        end
        @(negedge clk);
        total++;
        if (bus.Done !== 1'b0) begin
            bad++;
            $display("FAIL done_width got=%b want=0", bus.Done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            bus.Start      = 1'($urandom);
            bus.Accumulate = 1'($urandom);
            bus.Last       = 1'($urandom);
            bus.Out_Ready  = 1'($urandom);
            bus.PsumIn     = {$urandom, $urandom};
        end
        @(negedge clk);
        total++;
        if (bus.Busy !== 1'b0 || bus.Out_Valid !== 1'b0 || bus.Out_Data !== '0 ||
            bus.Out_Row !== '0 || bus.Done !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs busy=%b valid=%b data=%h row=%0d done=%b want all 0",
                     bus.Busy, bus.Out_Valid, bus.Out_Data, bus.Out_Row, bus.Done);
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        bus.Start = 1'b0;
        clear_model();
        repeat (5) begin
            @(negedge clk);
            total++;
            if (bus.Busy !== 1'b0 || bus.Out_Valid !== 1'b0 || bus.Out_Data !== '0 ||
                bus.Out_Row !== '0 || bus.Done !== 1'b0) begin
                bad++;
                $display("FAIL idle_after_reset busy=%b valid=%b data=%h row=%0d done=%b want all 0",
                         bus.Busy, bus.Out_Valid, bus.Out_Data, bus.Out_Row, bus.Done);
            end
        end
    endtask

    task automatic test_single_tile();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                ps[r][c] = 16'(10 * r + c);
        send_tile(1'b0, 1'b1, -1, -1);
        drain(-1, 0, 1'b0);
    endtask

    task automatic test_two_tiles();
        set_ps_const(16'd100);
        send_tile(1'b0, 1'b0, -1, -1);
        @(negedge clk);
        total++;
        if (bus.Busy !== 1'b0 || bus.Out_Valid !== 1'b0) begin
            bad++;
            $display("FAIL nonlast_tile busy=%b valid=%b want 0 0", bus.Busy, bus.Out_Valid);
        end
        set_ps_const(16'd23);
        send_tile(1'b1, 1'b1, -1, -1);
        drain(-1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                ps[r][c] = 16'($urandom);
        send_tile(1'b0, 1'b1, -1, -1);
        drain(1, 3, 1'b0);
    endtask

    task automatic test_ignored_start();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                ps[r][c] = 16'($urandom);
        send_tile(1'b1, 1'b1, 3, -1);
        drain(2, 2, 1'b1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                ps[r][c] = 16'($urandom);
        send_tile(1'b1, 1'b1, -1, 4);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                ps[r][c] = 16'(1000 + 7 * r + c);
        send_tile(1'b1, 1'b1, -1, -1);
        drain(-1, 0, 1'b0);
    endtask

    task automatic test_overflow();
        set_ps_const(16'hFFFF);
        send_tile(1'b0, 1'b0, -1, -1);
        for (int i = 1; i < 256; i++) send_tile(1'b1, 1'b0, -1, -1);
        set_ps_const(16'h00F0);
        send_tile(1'b1, 1'b0, -1, -1);
        set_ps_const(16'h0020);
        send_tile(1'b1, 1'b1, -1, -1);
        drain(-1, 0, 1'b0);
    endtask

    initial begin
        bus.Start      = 1'b0;
        bus.Accumulate = 1'b0;
        bus.Last       = 1'b0;
        bus.Out_Ready  = 1'b0;
        bus.PsumIn     = '0;
        clear_model();
        test_reset();
        test_single_tile();
        test_two_tiles();
        test_backpressure();
        test_ignored_start();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
